// File: rtl/spi_reg_pkg.sv
// Shared SPI definitions: slave FSM state type, cp_mode bit positions, frame
// width and small shift helpers used by both the receive and transmit paths.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_slave_state_e;

    localparam int unsigned CP_CPOL_BIT    = 1;
    localparam int unsigned CP_CPHA_BIT    = 0;
    localparam int unsigned SPI_FRAME_BITS = 8;

    // Shift a frame register by one bit, entering in_bit at the tail end.
    function automatic logic [SPI_FRAME_BITS-1:0] frame_shift(
        input logic [SPI_FRAME_BITS-1:0] v,
        input logic                      msb_first,
        input logic                      in_bit
    );
        return msb_first ? {v[SPI_FRAME_BITS-2:0], in_bit} : {in_bit, v[SPI_FRAME_BITS-1:1]};
    endfunction

    // Bit that goes out on the wire next.
    function automatic logic frame_head(
        input logic [SPI_FRAME_BITS-1:0] v,
        input logic                      msb_first
    );
        return msb_first ? v[SPI_FRAME_BITS-1] : v[0];
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-stage synchroniser with rise/fall pulse detection on the synchronised value.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : asynchronous input pin
//   q_o           : synchronised level
//   rise_o/fall_o : 1-cycle pulses on a synchronised 0->1 / 1->0 transition
// All flops reset to 0, so a pin already low at reset release never produces a
// fall pulse.
module spi_slave_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_slave.sv
// Single-lane SPI responder. Oversamples SCLK/SS/MOSI in the clk_i domain and
// exchanges 8-bit frames with the TX/RX FIFOs through pop/push pulses.
// Ports:
//   enable_i, cp_mode_i ([1]=CPOL,[0]=CPHA), msb_first_i : configuration
//   tx_data_i/tx_valid_i/tx_pop_o/tx_underrun_o          : TX FIFO side
//   rx_data_o/rx_valid_o                                  : RX FIFO side
//   busy_o                                                : frame in progress
//   spi_clk_i, spi_ss_i, spi_dq0_i                        : SCLK, SS_n, MOSI
//   spi_dq1_o, spi_dq1_oe_o                               : MISO and its enable
module spi_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] cp_mode_i,
    input  logic       msb_first_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_pop_o,
    output logic       tx_underrun_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    input  logic       spi_clk_i,
    input  logic       spi_ss_i,
    input  logic       spi_dq0_i,
    output logic       spi_dq1_o,
    output logic       spi_dq1_oe_o
);

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, unused_mosi_rise, unused_mosi_fall;
    logic unused_sclk_q, unused_ss_q;

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_clk_i),
        .q_o    (sclk_q),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_ss_i),
        .q_o    (ss_q),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spi_dq0_i),
        .q_o    (mosi_q),
        .rise_o (unused_mosi_rise),
        .fall_o (unused_mosi_fall)
    );

    assign unused_sclk_q = sclk_q;
    assign unused_ss_q   = ss_q;

    spi_slave_state_e state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             miso_q, miso_d;

    logic       cpol, cpha, in_shift;
    logic       sample_edge, shift_edge, byte_done, abort;
    logic [7:0] load_byte;

    assign cpol      = cp_mode_i[CP_CPOL_BIT];
    assign cpha      = cp_mode_i[CP_CPHA_BIT];
    assign in_shift  = (state_q == SHIFT);
    assign abort     = ss_rise | ~enable_i;
    assign load_byte = tx_valid_i ? tx_data_i : IDLE_FILL;

    assign sample_edge = in_shift & ((cpol == cpha) ? sclk_rise : sclk_fall);
    // With CPHA=0 the next frame's first bit is already driven at LOAD, so the
    // trailing shift edge of the previous frame (count back at 0) is skipped.
    assign shift_edge  = in_shift & ((cpol == cpha) ? sclk_fall : sclk_rise)
                       & (cpha | (bit_cnt_q != 3'd0));
    assign byte_done   = sample_edge & (bit_cnt_q == 3'(SPI_FRAME_BITS - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall && enable_i) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (byte_done) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        busy_o        = (state_q != IDLE);
        spi_dq1_oe_o  = (state_q != IDLE);
        tx_pop_o      = (state_q == LOAD) & tx_valid_i;
        tx_underrun_o = (state_q == LOAD) & ~tx_valid_i;
    end

    // Shift datapath
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = byte_done;
        miso_d     = miso_q;

        if (sample_edge) begin
            rx_sr_d   = frame_shift(rx_sr_q, msb_first_i, mosi_q);
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done) rx_data_d = rx_sr_d;

        if (state_q == LOAD) begin
            if (cpha) begin
                tx_sr_d = load_byte;
            end else begin
                miso_d  = frame_head(load_byte, msb_first_i);
                tx_sr_d = frame_shift(load_byte, msb_first_i, 1'b0);
            end
        end else if (shift_edge) begin
            miso_d  = frame_head(tx_sr_q, msb_first_i);
            tx_sr_d = frame_shift(tx_sr_q, msb_first_i, 1'b0);
        end

        // Leaving or staying in IDLE discards any partial frame.
        if (state_d == IDLE) begin
            bit_cnt_d = 3'd0;
            rx_sr_d   = 8'h00;
            miso_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q  <= 3'd0;
            rx_sr_q    <= 8'h00;
            tx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            miso_q     <= miso_d;
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign spi_dq1_o  = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 8;  // SCLK half period in clk_i cycles

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable_i = 1'b1;
    logic [1:0] cp_mode = 2'b00;
    logic       msb_first = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_ss = 1'b1;
    logic       spi_dq0 = 1'b0;

    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_pop_o, tx_underrun_o, rx_valid_o, busy_o;
    logic [7:0] rx_data_o;
    logic       spi_dq1_o, spi_dq1_oe_o;

    int checks = 0;
    int errors = 0;

    // Simple TX FIFO model: initial block writes, the pop process consumes.
    logic [7:0] tx_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign tx_valid_i = (wr_ptr != rd_ptr);
    assign tx_data_i  = tx_mem[rd_ptr[3:0]];

    always @(posedge clk_i) if (tx_pop_o) rd_ptr <= rd_ptr + 1;

    // Pulse monitors
    int         rx_cnt = 0;
    int         pop_cnt = 0;
    int         un_cnt = 0;
    logic [7:0] rx_hist [0:15];
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            rx_hist[rx_cnt % 16] = rx_data_o;
            rx_cnt++;
        end
        if (tx_pop_o) pop_cnt++;
        if (tx_underrun_o) un_cnt++;
    end

    always #5 clk_i = ~clk_i;

    spi_slave #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_FILL   (8'hFF)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .enable_i      (enable_i),
        .cp_mode_i     (cp_mode),
        .msb_first_i   (msb_first),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_pop_o      (tx_pop_o),
        .tx_underrun_o (tx_underrun_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .busy_o        (busy_o),
        .spi_clk_i     (spi_clk),
        .spi_ss_i      (spi_ss),
        .spi_dq0_i     (spi_dq0),
        .spi_dq1_o     (spi_dq1_o),
        .spi_dq1_oe_o  (spi_dq1_oe_o)
    );

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    task automatic set_mode(input logic [1:0] m, input logic mf);
        cp_mode   = m;
        msb_first = mf;
        spi_clk   = m[1];
        wait_clks(4);
    endtask

    task automatic ss_low();
        spi_ss = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic ss_high();
        spi_ss = 1'b1;
        wait_clks(HALF);
    endtask

    // Master side of nbits of a frame; captures MISO just before each sample edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic cpha;
        int   idx;
        cpha = cp_mode[0];
        mi   = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = msb_first ? 7 - i : i;
            if (cpha) spi_clk = ~spi_clk;
            spi_dq0 = mo[idx];
            wait_clks(HALF);
            mi[idx] = spi_dq1_o;
            spi_clk = ~spi_clk;
            wait_clks(HALF);
            if (!cpha) spi_clk = ~spi_clk;
        end
        if (!cpha) wait_clks(HALF);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        wait_clks(3);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (spi_dq1_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", spi_dq1_oe_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data_o); end
        checks++; if ({tx_pop_o, tx_underrun_o, rx_valid_o, spi_dq1_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got %b want 0000", {tx_pop_o, tx_underrun_o, rx_valid_o, spi_dq1_o});
        end
        rst_ni = 1'b1;
        wait_clks(4);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy_o); end
    endtask

    task automatic test_mode0_msb();
        logic [7:0] mi;
        int p0, r0;
        set_mode(2'b00, 1'b1);
        push_tx(8'h3C);
        p0 = pop_cnt; r0 = rx_cnt;
        ss_low();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL m0_busy got %b want 1", busy_o); end
        checks++; if (spi_dq1_oe_o !== 1'b1) begin errors++; $display("FAIL m0_oe got %b want 1", spi_dq1_oe_o); end
        spi_bits(8'hA5, 8, mi);
        checks++; if (pop_cnt - p0 != 1) begin errors++; $display("FAIL m0_pops got %0d want 1", pop_cnt - p0); end
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL m0_rx_cnt got %0d want 1", rx_cnt - r0); end
        checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL m0_rx_data got %h want a5", rx_data_o); end
        checks++; if (mi !== 8'h3C) begin errors++; $display("FAIL m0_miso got %h want 3c", mi); end
        ss_high();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL m0_idle got %b want 0", busy_o); end
    endtask

    task automatic test_mode3_lsb();
        logic [7:0] mi;
        int r0;
        set_mode(2'b11, 1'b0);
        push_tx(8'h6E);
        r0 = rx_cnt;
        ss_low();
        spi_bits(8'h81, 8, mi);
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL m3_rx_cnt got %0d want 1", rx_cnt - r0); end
        checks++; if (rx_data_o !== 8'h81) begin errors++; $display("FAIL m3_rx_data got %h want 81", rx_data_o); end
        checks++; if (mi !== 8'h6E) begin errors++; $display("FAIL m3_miso got %h want 6e", mi); end
        ss_high();
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int u0, p0, r0;
        set_mode(2'b00, 1'b1);
        u0 = un_cnt; p0 = pop_cnt; r0 = rx_cnt;
        ss_low();
        checks++; if (un_cnt - u0 != 1) begin errors++; $display("FAIL ur_underruns got %0d want 1", un_cnt - u0); end
        checks++; if (pop_cnt - p0 != 0) begin errors++; $display("FAIL ur_pops got %0d want 0", pop_cnt - p0); end
        spi_bits(8'h00, 8, mi);
        checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL ur_miso got %h want ff", mi); end
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL ur_rx_cnt got %0d want 1", rx_cnt - r0); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL ur_rx_data got %h want 00", rx_data_o); end
        ss_high();
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi1, mi2;
        int p0, r0;
        set_mode(2'b01, 1'b1);
        push_tx(8'h11);
        push_tx(8'h22);
        p0 = pop_cnt; r0 = rx_cnt;
        ss_low();
        spi_bits(8'hC3, 8, mi1);
        spi_bits(8'h5A, 8, mi2);
        wait_clks(4);
        checks++; if (pop_cnt - p0 != 2) begin errors++; $display("FAIL b2b_pops got %0d want 2", pop_cnt - p0); end
        checks++; if (rx_cnt - r0 != 2) begin errors++; $display("FAIL b2b_rx_cnt got %0d want 2", rx_cnt - r0); end
        checks++; if (rx_hist[r0 % 16] !== 8'hC3) begin errors++; $display("FAIL b2b_rx0 got %h want c3", rx_hist[r0 % 16]); end
        checks++; if (rx_hist[(r0 + 1) % 16] !== 8'h5A) begin errors++; $display("FAIL b2b_rx1 got %h want 5a", rx_hist[(r0 + 1) % 16]); end
        checks++; if (mi1 !== 8'h11) begin errors++; $display("FAIL b2b_miso0 got %h want 11", mi1); end
        checks++; if (mi2 !== 8'h22) begin errors++; $display("FAIL b2b_miso1 got %h want 22", mi2); end
        ss_high();
    endtask

    task automatic test_partial_abort();
        logic [7:0] mi;
        int r0;
        set_mode(2'b00, 1'b1);
        push_tx(8'h77);
        r0 = rx_cnt;
        ss_low();
        spi_bits(8'hF0, 5, mi);
        spi_ss = 1'b1;
        wait_clks(SYNC_STAGES + 2);
        checks++; if (spi_dq1_oe_o !== 1'b0) begin errors++; $display("FAIL pa_oe got %b want 0", spi_dq1_oe_o); end
        wait_clks(HALF);
        checks++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL pa_rx_cnt got %0d want 0", rx_cnt - r0); end
        checks++; if (rx_data_o !== 8'h5A) begin errors++; $display("FAIL pa_rx_data got %h want 5a", rx_data_o); end
        push_tx(8'h42);
        ss_low();
        spi_bits(8'h99, 8, mi);
        checks++; if (rx_data_o !== 8'h99) begin errors++; $display("FAIL pa_next_rx got %h want 99", rx_data_o); end
        checks++; if (mi !== 8'h42) begin errors++; $display("FAIL pa_next_miso got %h want 42", mi); end
        ss_high();
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] mi;
        int r0;
        set_mode(2'b00, 1'b1);
        push_tx(8'hE7);
        ss_low();
        spi_bits(8'hAA, 4, mi);
        rst_ni = 1'b0;
        wait_clks(2);
        checks++; if ({busy_o, spi_dq1_oe_o, spi_dq1_o, rx_valid_o, tx_pop_o} !== 5'b00000) begin
            errors++; $display("FAIL rm_outputs got %b want 00000", {busy_o, spi_dq1_oe_o, spi_dq1_o, rx_valid_o, tx_pop_o});
        end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rm_rx_data got %h want 00", rx_data_o); end
        rst_ni = 1'b1;
        r0 = rx_cnt;
        spi_bits(8'hF0, 8, mi);
        checks++; if (rx_cnt - r0 != 0) begin errors++; $display("FAIL rm_no_rx got %0d want 0", rx_cnt - r0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", busy_o); end
        push_tx(8'h3C);
        ss_high();
        ss_low();
        spi_bits(8'h3C, 8, mi);
        checks++; if (rx_cnt - r0 != 1) begin errors++; $display("FAIL rm_rx_cnt got %0d want 1", rx_cnt - r0); end
        checks++; if (rx_data_o !== 8'h3C) begin errors++; $display("FAIL rm_rx_data_after got %h want 3c", rx_data_o); end
        ss_high();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_underrun();
        test_back_to_back();
        test_partial_abort();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Single-lane (standard SPI) responder; the far end of the existing SPI master, used when ctrl0.role_mode selects slave.
- Samples the external SCLK, SS and MOSI pins in the clk_i domain through synchronisers and shifts 8-bit frames in and out.
- Exchanges bytes with the TX/RX sync_fifos in spi_core through a pop/push style handshake.
- Supports all four CPOL/CPHA modes and MSB-first or LSB-first bit order.

Parameters:
- SYNC_STAGES, 2, flop stages on spi_clk_i, spi_ss_i and spi_dq0_i (minimum 2).
- IDLE_FILL, 8'hFF, byte shifted out on MISO when no TX data is available.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- enable_i  input  1  slave enable; 0 holds the block in IDLE.
- cp_mode_i  input  2  [1]=CPOL, [0]=CPHA.
- msb_first_i  input  1  1 = bit 7 first.
- tx_data_i  input  8  next byte to send (FIFO head).
- tx_valid_i  input  1  tx_data_i valid (TX FIFO not empty).
- tx_pop_o  output  1  1-cycle pulse; the byte was taken.
- tx_underrun_o  output  1  1-cycle pulse; IDLE_FILL was loaded.
- rx_data_o  output  8  received byte.
- rx_valid_o  output  1  1-cycle pulse; rx_data_o valid (RX FIFO push).
- busy_o  output  1  SS asserted and transfer active.
- spi_clk_i  input  1  SCLK from the master.
- spi_ss_i  input  1  chip select, active-low.
- spi_dq0_i  input  1  MOSI.
- spi_dq1_o  output  1  MISO data.
- spi_dq1_oe_o  output  1  MISO output enable.

Behaviour:
- Reset values: all outputs 0; rx_data_o 8'h00; state IDLE; bit counter 0.
- Synchronisation: SCLK, SS and MOSI pass through SYNC_STAGES flops. An extra flop on SCLK and SS gives rise and fall pulses.
- SCLK frequency must be at most clk_i/8. Behaviour above that rate is not required.
- Sample edge is SCLK rising when CPOL==CPHA, otherwise falling. Shift edge is the opposite edge.
- SCLK edges while in IDLE are ignored.
- States:
  - IDLE: spi_dq1_oe_o=0. Leave on synchronised SS fall with enable_i=1 and go to LOAD.
  - LOAD (1 cycle): if tx_valid_i, capture tx_data_i into the shift-out register and pulse tx_pop_o. Otherwise capture IDLE_FILL and pulse tx_underrun_o. Then go to SHIFT. spi_dq1_oe_o=1 from here until return to IDLE.
  - SHIFT:
    - CPHA=0: first bit is on spi_dq1_o in the LOAD exit cycle; each later bit is driven on a shift edge.
    - CPHA=1: each bit, the first included, is driven on a shift edge.
    - On each sample edge, MOSI is shifted into the RX register (into bit 0 and left-shifted if MSB-first, into bit 7 and right-shifted if LSB-first) and the bit counter increments.
  - Byte complete (8th sample edge):
    - Next cycle: rx_data_o updates and rx_valid_o pulses once.
    - Bit counter wraps 7→0.
    - Next TX byte is loaded with the same rules as LOAD (pop or underrun), so the next frame starts on the following SCLK edges with no SS toggle.
- SS rise (synchronised), any state: go to IDLE next cycle and drop spi_dq1_oe_o.
  - A partial byte (count 1..7) is discarded: no rx_valid_o pulse, rx_data_o unchanged, bit counter cleared.
  - An already-popped TX byte is lost. There is no push-back.
- SS rise in the same cycle as the 8th sample edge: the byte completes and rx_valid_o pulses, but no further TX load happens.
- enable_i falling: same effect as SS rise.
- Held-constant rule: cp_mode_i and msb_first_i changes while busy_o=1 are undefined. The bench holds them constant.
- busy_o = 1 in LOAD and SHIFT.
- rx_valid_o and tx_pop_o never assert in the same cycle as reset release.
- Reset during a transfer: immediate return to reset values. When SS is still low at reset release, the block waits for the next SS fall.

Decomposition:
- spi_reg_pkg (shared) holds:
  - the state enum spi_slave_state_e {IDLE, LOAD, SHIFT};
  - localparams CP_CPOL_BIT=1 and CP_CPHA_BIT=0;
  - SPI_FRAME_BITS=8.
- One sub-module, spi_slave_sync: an N-stage synchroniser plus rise/fall detect, instantiated for SCLK and SS. MOSI uses the same module with its edge outputs unused.
- Integration: spi_core muxes the pin OE signals on role_mode, wires rx_valid_o to rx_fifo_push, and wires tx_pop_o to tx_fifo_pop.

Test Plan:
- Mode 0, MSB-first; master sends 0xA5; tx_data_i=0x3C, tx_valid_i=1 → tx_pop_o pulses once; rx_data_o=0xA5 with one rx_valid_o pulse; MISO bit sequence 0,0,1,1,1,1,0,0.
- Mode 3, LSB-first; master sends 0x81; tx_data_i=0x6E → rx_data_o=0x81; MISO sequence 0,1,1,1,0,1,1,0.
- tx_valid_i=0 at SS fall; master sends 0x00 → tx_underrun_o pulses once; MISO shows 0xFF; rx_data_o=0x00 with valid.
- Back-to-back in mode 1 with SS held low: TX bytes 0x11 then 0x22, master sends 0xC3 then 0x5A → two tx_pop_o pulses, two rx_valid_o pulses (0xC3, then 0x5A), no gap bits.
- SS released after 5 sample edges → no rx_valid_o; spi_dq1_oe_o=0 within SYNC_STAGES+2 cycles; the next full 0x99 frame is received correctly.
- rst_ni asserted mid-byte, released with SS low → all outputs 0; no rx_valid_o until SS goes high and then low again.
